// File: rtl/inst_queue_pkg.sv
// Shared types and constants for the instruction queue between fetch and decode/issue.
// Optional build macro INST_QUEUE_BYPASS_EN is consumed by inst_queue.sv.
package inst_queue_pkg;

  localparam int IQ_SIZE  = 16;
  localparam int IQ_POS_W = 4;

  typedef logic [31:0]         inst_t;
  typedef logic [31:0]         addr_t;
  typedef logic [IQ_POS_W-1:0] iq_pos_t;

  localparam logic  TRUE      = 1'b1;
  localparam logic  FALSE     = 1'b0;
  localparam inst_t ZERO_WORD = 32'h0000_0000;

  typedef struct packed {
    inst_t inst;
    addr_t pc;
    logic  pred_jump;
  } iq_entry_t;

  localparam iq_entry_t IQ_ENTRY_ZERO = '{inst: ZERO_WORD, pc: ZERO_WORD, pred_jump: FALSE};

endpackage

// File: rtl/inst_queue.sv
// Instruction queue: circular FIFO of {inst, pc, pred_jump} from the fetcher to decode/issue.
// Define INST_QUEUE_BYPASS_EN to let an empty queue forward the incoming entry in the same cycle.
module inst_queue
  import inst_queue_pkg::*;
#(
  parameter int IQ_DEPTH = IQ_SIZE,
  parameter int IQ_PTR_W = IQ_POS_W
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        flush,
  input  logic        in_valid,
  input  logic [31:0] in_inst,
  input  logic [31:0] in_pc,
  input  logic        in_pred_jump,
  output logic        iq_full,
  input  logic        out_ready,
  output logic        out_valid,
  output logic [31:0] out_inst,
  output logic [31:0] out_pc,
  output logic        out_pred_jump
);

  typedef logic [IQ_PTR_W-1:0] ptr_t;
  typedef logic [IQ_PTR_W:0]   cnt_t;

  localparam cnt_t DEPTH_C = cnt_t'(IQ_DEPTH);

  inst_t inst_mem [IQ_DEPTH];
  addr_t pc_mem   [IQ_DEPTH];
  logic  pred_mem [IQ_DEPTH];

  ptr_t head_q, head_d;
  ptr_t tail_q, tail_d;
  cnt_t count_q, count_d;

  logic empty;
  logic full;
  logic bypass;
  logic push;
  logic pop;

  assign empty = (count_q == '0);
  assign full  = (count_q == DEPTH_C);

`ifdef INST_QUEUE_BYPASS_EN
  // An empty queue hands the incoming word straight to issue; nothing is stored.
  assign bypass = rdy & in_valid & out_ready & ~flush & empty;
`else
  assign bypass = FALSE;
`endif

  assign push = rdy & ~flush & in_valid & ~full & ~bypass;
  assign pop  = rdy & ~flush & ~empty & out_ready;

  // NOTE: every always_comb output is given a default first so no latch is inferred.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (rdy && flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (push) tail_d = tail_q + 1'b1;
      if (pop)  head_d = head_q + 1'b1;
      unique case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  // NOTE: sequential state is written with non-blocking assignments only.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // NOTE: storage arrays carry no reset; count_q alone decides which slots are meaningful.
  always_ff @(posedge clk) begin
    if (push) begin
      inst_mem[tail_q] <= in_inst;
      pc_mem[tail_q]   <= in_pc;
      pred_mem[tail_q] <= in_pred_jump;
    end
  end

  always_comb begin
    out_valid     = FALSE;
    out_inst      = IQ_ENTRY_ZERO.inst;
    out_pc        = IQ_ENTRY_ZERO.pc;
    out_pred_jump = IQ_ENTRY_ZERO.pred_jump;
    if (bypass) begin
      out_valid     = TRUE;
      out_inst      = in_inst;
      out_pc        = in_pc;
      out_pred_jump = in_pred_jump;
    end else if (!empty) begin
      out_valid     = TRUE;
      out_inst      = inst_mem[head_q];
      out_pc        = pc_mem[head_q];
      out_pred_jump = pred_mem[head_q];
    end
  end

  assign iq_full = full;

`ifndef SYNTHESIS
  always @(posedge clk) begin
    if (rst && rdy && in_valid && full)
      $warning("inst_queue: push while full dropped (inst=0x%08h pc=0x%08h)", in_inst, in_pc);
  end
`endif

endmodule
